fault_monitor_p: RTL and testbench

- Parametrised successor to the 8-bit fault checker. Monitors a stream of WIDTH-bit words in blocks of DEPTH words.
- Checks each block in one of four modes selected by check: even parity, odd parity, block checksum or duplicate compare.
- Accumulates a saturating error count, keeps a sticky fault flag, and locks out input once a threshold is reached.
- Sits beside the existing co-processor, fed from the same r0/check inputs.

---
 rtl/fault_monitor_p_if.sv | 30 +++
 rtl/fault_monitor_p.sv | 173 +++++++++++++++++
 tb/tb_fault_monitor_p.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fault_monitor_p_if.sv
// Word stream and status bundle between a fault_monitor_p instance and its producer.
// The producer drives data, mode and clear; the monitor returns handshake and check results.
interface fault_monitor_p_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
);
  localparam int ERR_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r0;
  logic             valid;
  logic [1:0]       check;
  logic             clr;
  logic             ready;
  logic [1:0]       state;
  logic [ERR_W-1:0] last_errs;
  logic [CNT_W-1:0] err_cnt;
  logic             fault;
  logic             done;

  modport master (
    output r0, valid, check, clr,
    input  ready, state, last_errs, err_cnt, fault, done
  );

  modport slave (
    input  r0, valid, check, clr,
    output ready, state, last_errs, err_cnt, fault, done
  );
endinterface

// File: rtl/fault_monitor_p.sv
// Block-wise word checker: parity, checksum or duplicate compare over DEPTH words,
// with a saturating error count, sticky fault flag and lockout at THRESH errors.
module fault_monitor_p #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  fault_monitor_p_if.slave bus
);
  localparam int ERR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + ERR_W;
  localparam logic [SUM_W-1:0] CNT_MAX  = {{ERR_W{1'b0}}, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    EVAL    = 2'b10,
    LOCK    = 2'b11
  } state_t;

  function automatic logic parity_f(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // Error contribution of one word; checksum and pair errors surface on the closing word.
  function automatic logic word_err_f(input logic [1:0] mode, input logic [IDX_W-1:0] idx,
                                      input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] sum,
                                      input logic [WIDTH-1:0] even_w);
    logic e;
    e = 1'b0;
    case (mode)
      2'b00:   e = parity_f(w);
      2'b01:   e = ~parity_f(w);
      2'b10:   e = (idx == LAST_IDX) && (sum != w);
      2'b11:   e = idx[0] && (w != even_w);
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [1:0]       mode_r, mode_nxt_s, eff_mode_s;
  logic [ERR_W-1:0] err_acc_r, err_acc_nxt_s, inc_s;
  logic [WIDTH-1:0] sum_r, sum_nxt_s, even_r, even_nxt_s;
  logic [ERR_W-1:0] last_errs_r, last_errs_nxt_s;
  logic [CNT_W-1:0] err_cnt_r, err_cnt_nxt_s, cnt_sat_s;
  logic [SUM_W-1:0] cnt_sum_s;
  logic             fault_r, fault_nxt_s, done_r, done_nxt_s, ready_r, ready_nxt_s;
  logic             word_err_s;

  // Next-state and next-value logic for the block FSM and its accumulators.
  always_comb begin
    state_nxt_s     = state_r;
    idx_nxt_s       = idx_r;
    mode_nxt_s      = mode_r;
    err_acc_nxt_s   = err_acc_r;
    sum_nxt_s       = sum_r;
    even_nxt_s      = even_r;
    last_errs_nxt_s = last_errs_r;
    err_cnt_nxt_s   = err_cnt_r;
    fault_nxt_s     = fault_r;
    done_nxt_s      = 1'b0;

    eff_mode_s = (state_r == IDLE) ? bus.check : mode_r;
    word_err_s = word_err_f(eff_mode_s, idx_r, bus.r0, sum_r, even_r);
    inc_s      = {{(ERR_W-1){1'b0}}, word_err_s};
    cnt_sum_s  = {{ERR_W{1'b0}}, err_cnt_r} + {{CNT_W{1'b0}}, err_acc_r};
    cnt_sat_s  = (cnt_sum_s > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];

    if (bus.clr) begin
      state_nxt_s   = IDLE;
      idx_nxt_s     = {IDX_W{1'b0}};
      err_acc_nxt_s = {ERR_W{1'b0}};
      sum_nxt_s     = {WIDTH{1'b0}};
      even_nxt_s    = {WIDTH{1'b0}};
      err_cnt_nxt_s = {CNT_W{1'b0}};
      fault_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.valid) begin
            mode_nxt_s    = bus.check;
            err_acc_nxt_s = inc_s;
            sum_nxt_s     = bus.r0;
            even_nxt_s    = bus.r0;
            idx_nxt_s     = IDX_W'(1);
            state_nxt_s   = COLLECT;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        COLLECT: begin
          if (bus.valid) begin
            err_acc_nxt_s = err_acc_r + inc_s;
            sum_nxt_s     = sum_r + bus.r0;
            if (!idx_r[0]) begin
              even_nxt_s = bus.r0;
            end else begin
              even_nxt_s = even_r;
            end
            if (idx_r == LAST_IDX) begin
              idx_nxt_s   = {IDX_W{1'b0}};
              state_nxt_s = EVAL;
            end else begin
              idx_nxt_s = idx_r + IDX_W'(1);
            end
          end else begin
            state_nxt_s = COLLECT;
          end
        end
        EVAL: begin
          last_errs_nxt_s = err_acc_r;
          err_cnt_nxt_s   = cnt_sat_s;
          fault_nxt_s     = fault_r | (err_acc_r != {ERR_W{1'b0}});
          done_nxt_s      = 1'b1;
          err_acc_nxt_s   = {ERR_W{1'b0}};
          state_nxt_s     = (cnt_sat_s >= THRESH_C) ? LOCK : IDLE;
        end
        LOCK: begin
          state_nxt_s = LOCK;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end

    ready_nxt_s = (state_nxt_s == IDLE) || (state_nxt_s == COLLECT);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      mode_r      <= 2'b00;
      err_acc_r   <= {ERR_W{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      even_r      <= {WIDTH{1'b0}};
      last_errs_r <= {ERR_W{1'b0}};
      err_cnt_r   <= {CNT_W{1'b0}};
      fault_r     <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      mode_r      <= mode_nxt_s;
      err_acc_r   <= err_acc_nxt_s;
      sum_r       <= sum_nxt_s;
      even_r      <= even_nxt_s;
      last_errs_r <= last_errs_nxt_s;
      err_cnt_r   <= err_cnt_nxt_s;
      fault_r     <= fault_nxt_s;
      done_r      <= done_nxt_s;
      ready_r     <= ready_nxt_s;
    end
  end

  assign bus.state     = state_r;
  assign bus.ready     = ready_r;
  assign bus.last_errs = last_errs_r;
  assign bus.err_cnt   = err_cnt_r;
  assign bus.fault     = fault_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_fault_monitor_p.sv
// Directed bench for fault_monitor_p: a vector table for the streaming cases and
// hand sequences for lockout, saturation (THRESH=7 instance) and async reset.
module tb_fault_monitor_p;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fault_monitor_p_if bus ();
  fault_monitor_p_if bus7 ();

  fault_monitor_p dut (.clk(clk), .reset(reset), .bus(bus));
  fault_monitor_p #(.THRESH(7)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

  assign bus7.r0    = bus.r0;
  assign bus7.valid = bus.valid;
  assign bus7.check = bus.check;
  assign bus7.clr   = bus.clr;

  typedef struct {
    logic       clr;
    logic       valid;
    logic [1:0] check;
    logic [7:0] r0;
    logic [1:0] st;
    logic       rdy;
    logic       dn;
    logic [2:0] le;
    logic [2:0] ec;
    logic       flt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic v, input logic [1:0] ck, input logic [7:0] d);
    bus.clr   = c;
    bus.valid = v;
    bus.check = ck;
    bus.r0    = d;
  endtask

  task automatic check_main(input string tag, input logic [1:0] st, input logic rdy, input logic dn,
                            input logic [2:0] le, input logic [2:0] ec, input logic flt);
    chk({tag, " state"}, 32'(bus.state), 32'(st));
    chk({tag, " ready"}, 32'(bus.ready), 32'(rdy));
    chk({tag, " done"}, 32'(bus.done), 32'(dn));
    chk({tag, " last_errs"}, 32'(bus.last_errs), 32'(le));
    chk({tag, " err_cnt"}, 32'(bus.err_cnt), 32'(ec));
    chk({tag, " fault"}, 32'(bus.fault), 32'(flt));
  endtask

  task automatic check_b7(input string tag, input logic [1:0] st, input logic rdy, input logic dn,
                          input logic [2:0] le, input logic [2:0] ec, input logic flt);
    chk({tag, " state"}, 32'(bus7.state), 32'(st));
    chk({tag, " ready"}, 32'(bus7.ready), 32'(rdy));
    chk({tag, " done"}, 32'(bus7.done), 32'(dn));
    chk({tag, " last_errs"}, 32'(bus7.last_errs), 32'(le));
    chk({tag, " err_cnt"}, 32'(bus7.err_cnt), 32'(ec));
    chk({tag, " fault"}, 32'(bus7.fault), 32'(flt));
  endtask

  function automatic void add(input logic c, input logic v, input logic [1:0] ck, input logic [7:0] d,
                              input logic [1:0] st, input logic rdy, input logic dn,
                              input logic [2:0] le, input logic [2:0] ec, input logic flt);
    vec_t r;
    r.clr = c; r.valid = v; r.check = ck; r.r0 = d;
    r.st = st; r.rdy = rdy; r.dn = dn; r.le = le; r.ec = ec; r.flt = flt;
    vecs.push_back(r);
  endfunction

  initial begin
    // even parity 03,05,07,0F: one odd word
    add(1'b0, 1'b1, 2'd0, 8'h03, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 8'h05, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 8'h07, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 8'h0F, 2'd2, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1);
    add(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0, 3'd1, 3'd1, 1'b1);
    add(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0);
    // checksum good, then a word offered during EVAL is dropped
    add(1'b0, 1'b1, 2'd2, 8'h10, 2'd1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd2, 8'h20, 2'd1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd2, 8'h30, 2'd1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd2, 8'h60, 2'd2, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd2, 8'h11, 2'd0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0);
    // checksum bad
    add(1'b0, 1'b1, 2'd2, 8'h10, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd2, 8'h20, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd2, 8'h30, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd2, 8'h61, 2'd2, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b0, 2'd2, 8'h00, 2'd0, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1);
    // checksum with modular wrap FF+02+00 = 01
    add(1'b0, 1'b1, 2'd2, 8'hFF, 2'd1, 1'b1, 1'b0, 3'd1, 3'd1, 1'b1);
    add(1'b0, 1'b1, 2'd2, 8'h02, 2'd1, 1'b1, 1'b0, 3'd1, 3'd1, 1'b1);
    add(1'b0, 1'b1, 2'd2, 8'h00, 2'd1, 1'b1, 1'b0, 3'd1, 3'd1, 1'b1);
    add(1'b0, 1'b1, 2'd2, 8'h01, 2'd2, 1'b0, 1'b0, 3'd1, 3'd1, 1'b1);
    add(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b1, 3'd0, 3'd1, 1'b1);
    add(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    // duplicate, mode changed mid-block, 3-cycle stall
    add(1'b0, 1'b1, 2'd3, 8'hAA, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 8'hAA, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 8'h55, 2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 8'h54, 2'd2, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1);
    // duplicate 01,01,03,03: zero errors, would be two under even parity
    add(1'b0, 1'b1, 2'd3, 8'h01, 2'd1, 1'b1, 1'b0, 3'd1, 3'd1, 1'b1);
    add(1'b0, 1'b1, 2'd0, 8'h01, 2'd1, 1'b1, 1'b0, 3'd1, 3'd1, 1'b1);
    add(1'b0, 1'b1, 2'd0, 8'h03, 2'd1, 1'b1, 1'b0, 3'd1, 3'd1, 1'b1);
    add(1'b0, 1'b1, 2'd0, 8'h03, 2'd2, 1'b0, 1'b0, 3'd1, 3'd1, 1'b1);
    add(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b1, 3'd0, 3'd1, 1'b1);

    drive(1'b0, 1'b0, 2'd0, 8'h00);
    reset = 1'b0;
    tick();
    tick();
    check_main("reset", 2'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].valid, vecs[i].check, vecs[i].r0);
      tick();
      check_main($sformatf("row%0d", i), vecs[i].st, vecs[i].rdy, vecs[i].dn,
                 vecs[i].le, vecs[i].ec, vecs[i].flt);
    end

    // lock after four odd-parity errors, inputs ignored, clr releases
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'd1, 8'h00);
      tick();
    end
    chk("lock eval state", 32'(bus.state), 32'd2);
    drive(1'b0, 1'b0, 2'd1, 8'h00);
    tick();
    check_main("lock entry", 2'd3, 1'b0, 1'b1, 3'd4, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'd0, 8'h07);
      tick();
      check_main($sformatf("lock hold%0d", i), 2'd3, 1'b0, 1'b0, 3'd4, 3'd4, 1'b1);
    end
    drive(1'b1, 1'b1, 2'd0, 8'h07);
    tick();
    check_main("lock clr", 2'd0, 1'b1, 1'b0, 3'd4, 3'd0, 1'b0);

    // saturation on the THRESH=7 instance: 4 then 7, lock on second done
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 1'b1, 2'd1, 8'h00);
        tick();
      end
      drive(1'b0, 1'b0, 2'd1, 8'h00);
      tick();
      if (b == 0) check_b7("sat blk0", 2'd0, 1'b1, 1'b1, 3'd4, 3'd4, 1'b1);
      else        check_b7("sat blk1", 2'd3, 1'b0, 1'b1, 3'd4, 3'd7, 1'b1);
    end
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    tick();
    chk("sat clr err_cnt", 32'(bus7.err_cnt), 32'd0);

    // async reset mid-block discards two erroring words
    drive(1'b0, 1'b1, 2'd0, 8'h07);
    tick();
    drive(1'b0, 1'b1, 2'd0, 8'h01);
    tick();
    chk("pre-reset state", 32'(bus.state), 32'd1);
    chk("pre-reset last_errs", 32'(bus.last_errs), 32'd4);
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    #2 reset = 1'b0;
    #1;
    check_main("async reset", 2'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    #1 reset = 1'b1;
    drive(1'b0, 1'b1, 2'd0, 8'h03);
    tick();
    drive(1'b0, 1'b1, 2'd0, 8'h05);
    tick();
    drive(1'b0, 1'b1, 2'd0, 8'h06);
    tick();
    chk("post-reset word3 state", 32'(bus.state), 32'd1);
    drive(1'b0, 1'b1, 2'd0, 8'h0F);
    tick();
    chk("post-reset word4 state", 32'(bus.state), 32'd2);
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    check_main("post-reset block", 2'd0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
